// File: rtl/mips_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package mips_pkg;

    localparam int          FIFO_DEPTH_DEFAULT   = 2;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order buffer of fetched {pc, instruction} pairs; flush wins over push/pop.
module fetch_buf
    import mips_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    logic [1:0]   count_reg;
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic         do_push;
    logic         do_pop;
    fetch_entry_t entry_q [2];

    assign full    = (count_reg == 2'(DEPTH));
    assign empty   = (count_reg == 2'd0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            fetch_entry_t entry_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_reg <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_data;
                end
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else if (flush) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head = entry_q[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the PC register, issues memory requests, and
// buffers responses for decode, dropping responses made stale by a branch.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int          FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    fetch_state_t state_reg;
    logic [31:0]  req_addr_reg;
    logic         accept;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t head;
    fetch_entry_t push_data;

    // A response is kept only when it lands in FETCH and no redirect is in flight.
    assign accept    = (state_reg == FETCH) && imem_ack && !branch_taken;
    assign pop       = !empty && id_ready && !branch_taken;
    assign push_data = '{pc: req_addr_reg, instr: imem_rdata};

    fetch_buf #(.DEPTH(FIFO_DEPTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .pop       (pop),
        .flush     (branch_taken),
        .push_data (push_data),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    always_comb begin
        next = pc;
        if (branch_taken) begin
            next = branch_target;
        end else if (accept) begin
            next = req_addr_reg + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            req_addr_reg <= RESET_VECTOR;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg    <= FETCH;
                    req_addr_reg <= branch_taken ? branch_target : pc;
                end
                FETCH: begin
                    if (branch_taken) begin
                        if (imem_ack) begin
                            req_addr_reg <= branch_target;
                        end else begin
                            state_reg <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        // FETCH only runs with occupancy <= 1, so room remains unless it was 1 with no pop.
                        if (empty || pop) begin
                            req_addr_reg <= req_addr_reg + 32'd4;
                        end else begin
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        state_reg    <= FETCH;
                        req_addr_reg <= branch_target;
                    end else if (!full || pop) begin
                        state_reg    <= FETCH;
                        req_addr_reg <= pc;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_reg    <= FETCH;
                        req_addr_reg <= branch_taken ? branch_target : pc;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign imem_req  = (state_reg == FETCH) || (state_reg == DISCARD);
    assign imem_addr = req_addr_reg;
    assign if_valid  = !empty;
    assign if_instr  = head.instr;
    assign if_pc     = head.pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of fetched-instruction buffer entries; only value 2 is supported.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, start address; must match the PC register reset value.
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  input  32  current fetch address from the PC register.
REQ-006 next  output  32  next fetch address, fed to the PC register.
REQ-007 branch_taken  input  1  redirect request from execute.
REQ-008 branch_target  input  32  redirect address, valid with branch_taken.
REQ-009 imem_req  output  1  instruction-memory request.
REQ-010 imem_addr  output  32  request address, stable while imem_req=1 and imem_ack=0.
REQ-011 imem_ack  input  1  memory response valid; completes the outstanding request.
REQ-012 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-013 if_valid  output  1  buffer head holds a valid instruction.
REQ-014 if_instr  output  32  instruction at buffer head.
REQ-015 if_pc  output  32  address of if_instr.
REQ-016 id_ready  input  1  decode accepts the head; a pop occurs when if_valid and id_ready are both 1.

Function
REQ-017 next is combinational with this priority: branch_taken gives branch_target; an accepted ack gives req_addr+4; otherwise it gives pc (hold).
REQ-018 There are four states: IDLE, FETCH, HOLD and DISCARD; imem_req=1 only in FETCH and DISCARD; imem_addr=req_addr, an internal register.
REQ-019 IDLE lasts one cycle after reset release, then goes to FETCH with req_addr<=pc.
REQ-020 In FETCH, an ack without branch_taken pushes {req_addr, imem_rdata}.
REQ-021 After such a push, if occupancy after push-and-pop is below 2, the block stays in FETCH with req_addr<=req_addr+4; otherwise it goes to HOLD.
REQ-022 Zero-wait memory (ack in the same cycle as req) sustains one instruction per cycle.
REQ-023 In HOLD, when occupancy after the pop is below 2, the block goes to FETCH with req_addr<=pc.
REQ-024 branch_taken clears the buffer at the clock edge (if_valid=0 the next cycle); a pop in the same cycle is ignored.
REQ-025 branch_taken in FETCH without ack goes to DISCARD, keeping req_addr and imem_req.
REQ-026 branch_taken in FETCH with ack drops the response and goes to FETCH with req_addr<=branch_target.
REQ-027 In DISCARD, an ack drops the response and goes to FETCH with req_addr<=pc; branch_taken in DISCARD stays in DISCARD.
REQ-028 branch_taken in HOLD or IDLE goes to FETCH with req_addr<=branch_target.
REQ-029 imem_ack outside FETCH/DISCARD is ignored.
REQ-030 A push never occurs to a full buffer; a simultaneous push and pop at occupancy 1 leaves occupancy 1.
REQ-031 The buffer is in-order: if_instr and if_pc always come from the oldest entry.
REQ-032 Address arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-033 During reset: state=IDLE, occupancy=0, if_valid=0, imem_req=0, req_addr=RESET_VECTOR, if_instr=0, if_pc=0.
REQ-034 Reset mid-request abandons the outstanding access; a stale ack in IDLE is ignored.

Structure
REQ-035 The state encoding and the FIFO_DEPTH/RESET_VECTOR defaults reside in the shared package mips_pkg.
REQ-036 The two-entry buffer is a sub-module, fetch_buf (push, pop, flush, full, empty, head data).

Verification
REQ-037 Reset release, zero-wait memory returning 32'h2000_0000+addr, id_ready=1 -> if_pc sequence 0,4,8,12 on consecutive cycles; next=pc+4 each ack.
REQ-038 id_ready=0 for 5 cycles -> exactly 2 entries buffered, imem_req=0 in HOLD, next=pc; id_ready=1 -> resumes with no lost or duplicated if_pc.
REQ-039 3-cycle ack latency, branch_taken with target 32'h0000_0100 in the first wait cycle -> old response dropped, next request address 0x100, first if_pc=0x100.
REQ-040 branch_taken coincident with ack and pop at occupancy 1 -> buffer empty next cycle, req_addr=branch_target.
REQ-041 pc=32'hFFFF_FFFC, ack -> next=0.
REQ-042 reset asserted while imem_req=1 and ack pending, ack one cycle after release -> ignored, if_valid stays 0, fetch restarts at RESET_VECTOR.
